// File: rtl/approx_mult_pkg.sv
// Shared constants and helpers for the approximate multiplier pipeline.
//   MODE_EXACT / MODE_APPROX : values of the per-beat mode bit
//   MAX_W                    : largest supported operand width
//   col_mask()               : flattened map of kept partial-product bits
package approx_mult_pkg;

    localparam int unsigned MAX_W  = 16;
    localparam int unsigned MASK_W = MAX_W * MAX_W;

    localparam logic MODE_EXACT  = 1'b0;
    localparam logic MODE_APPROX = 1'b1;

    // Bit (i*MAX_W + j) is set when partial product a[j]&b[i] lands in a
    // column i+j that survives truncation, for operands of the given width.
    function automatic logic [MASK_W-1:0] col_mask(input int unsigned width,
                                                    input int unsigned trunc);
        logic [MASK_W-1:0] m;
        m = '0;
        for (int unsigned i = 0; i < MAX_W; i++) begin
            for (int unsigned j = 0; j < MAX_W; j++) begin
                if ((i < width) && (j < width) && ((i + j) >= trunc)) begin
                    m[i*MAX_W + j] = 1'b1;
                end
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/approx_mult_csa.sv
// Combinational carry-save column reduction for the approximate multiplier.
// Partial-product rows are masked by mode (all kept in exact mode, only
// columns >= TRUNC in approximate mode) and compressed with 3:2 counters
// into a redundant sum/carry pair whose modular sum is the product.
// Build option: APPROX_MULT_COMP_EN adds a 2^TRUNC compensation row in
// approximate mode.
//   a, b   : unsigned operands, WIDTH bits
//   mode   : MODE_EXACT or MODE_APPROX
//   sum    : carry-save sum vector, 2*WIDTH bits
//   carry  : carry-save carry vector, 2*WIDTH bits (already weight-aligned)
module approx_mult_csa
    import approx_mult_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned TRUNC = 4
) (
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               mode,
    output logic [2*WIDTH-1:0] sum,
    output logic [2*WIDTH-1:0] carry
);

    localparam int unsigned PW = 2 * WIDTH;
    localparam logic [MASK_W-1:0] KEEP = col_mask(WIDTH, TRUNC);

    logic [PW-1:0] row;
    logic [PW-1:0] s_acc;
    logic [PW-1:0] c_acc;
    logic [PW-1:0] s_nxt;
`ifdef APPROX_MULT_COMP_EN
    logic [PW-1:0] comp;
`endif

    // Build each partial-product row and fold it into the running s/c pair.
    always_comb begin : reduce
        row   = '0;
        s_acc = '0;
        c_acc = '0;
        s_nxt = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            row = '0;
            for (int unsigned j = 0; j < WIDTH; j++) begin
                row[i + j] = a[j] & b[i] &
                             ((mode == MODE_EXACT) | KEEP[i*MAX_W + j]);
            end
            s_nxt = s_acc ^ c_acc ^ row;
            c_acc = ((s_acc & c_acc) | (s_acc & row) | (c_acc & row)) << 1;
            s_acc = s_nxt;
        end
`ifdef APPROX_MULT_COMP_EN
        // Compensation enters as one more carry-save row so the final adder
        // in stage 2 stays a plain two-input add.
        comp = '0;
        if (mode == MODE_APPROX) begin
            comp = PW'(1) << TRUNC;
        end
        s_nxt = s_acc ^ c_acc ^ comp;
        c_acc = ((s_acc & c_acc) | (s_acc & comp) | (c_acc & comp)) << 1;
        s_acc = s_nxt;
`endif
    end

    assign sum   = s_acc;
    assign carry = c_acc;

endmodule

// File: rtl/approx_mult_pipe.sv
// Two-stage pipelined unsigned multiplier with exact/approximate modes and
// valid/ready handshakes on both sides. Stage 1 registers the carry-save
// reduction, stage 2 registers the carry-propagate sum.
// Build option: APPROX_MULT_COMP_EN enables approximate-mode compensation
// (implemented inside approx_mult_csa).
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid / in_ready : operand beat handshake (in_ready is combinational)
//   a, b, mode          : operands and per-beat mode
//   out_valid/out_ready : result handshake
//   y, y_mode           : product (2*WIDTH bits) and the mode it used
module approx_mult_pipe
    import approx_mult_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned TRUNC = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               mode,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] y,
    output logic               y_mode
);

    localparam int unsigned PW = 2 * WIDTH;

    logic [PW-1:0] csa_sum;
    logic [PW-1:0] csa_carry;

    logic          s1_valid;
    logic [PW-1:0] s1_sum;
    logic [PW-1:0] s1_carry;
    logic          s1_mode;

    logic          s2_adv;
    logic          s1_adv;

    approx_mult_csa #(
        .WIDTH (WIDTH),
        .TRUNC (TRUNC)
    ) u_csa (
        .a     (a),
        .b     (b),
        .mode  (mode),
        .sum   (csa_sum),
        .carry (csa_carry)
    );

    // Advance conditions: a stage moves when empty or when it can hand off.
    always_comb begin : advance
        s2_adv   = !out_valid || out_ready;
        s1_adv   = !s1_valid || s2_adv;
        in_ready = !s1_valid || (s1_valid && s2_adv);
    end

    // Stage 1: capture the redundant product and its mode with the beat.
    always_ff @(posedge clk or negedge rst_n) begin : stage1
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_sum   <= '0;
            s1_carry <= '0;
            s1_mode  <= MODE_EXACT;
        end else if (s1_adv) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_sum   <= csa_sum;
                s1_carry <= csa_carry;
                s1_mode  <= mode;
            end
        end
    end

    // Stage 2: resolve sum + carry; result holds while stalled.
    always_ff @(posedge clk or negedge rst_n) begin : stage2
        if (!rst_n) begin
            out_valid <= 1'b0;
            y         <= '0;
            y_mode    <= MODE_EXACT;
        end else if (s2_adv) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                y      <= s1_sum + s1_carry;
                y_mode <= s1_mode;
            end
        end
    end

endmodule

// File: tb/tb_approx_mult_pipe.sv
// Self-checking bench for approx_mult_pipe (WIDTH=8, TRUNC=4): directed
// vectors, a stalled stream, randomized traffic and a mid-flight reset,
// all scored against a product-level reference model.
module tb_approx_mult_pipe;

    localparam int W = 8;
    localparam int T = 4;

`ifdef APPROX_MULT_COMP_EN
    localparam logic [15:0] Y_FF_APX = 16'd64992;
    localparam logic [15:0] Y_F0_APX = 16'd57616;
    localparam logic [15:0] Y_0F_APX = 16'd192;
`else
    localparam logic [15:0] Y_FF_APX = 16'd64976;
    localparam logic [15:0] Y_F0_APX = 16'd57600;
    localparam logic [15:0] Y_0F_APX = 16'd176;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          mode;
    logic          out_valid;
    logic          out_ready;
    logic [2*W-1:0] y;
    logic          y_mode;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    bit lat_chk = 1'b0;

    logic [15:0] q_y[$];
    logic        q_m[$];
    int          q_c[$];

    approx_mult_pipe #(.WIDTH(W), .TRUNC(T)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .mode      (mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y),
        .y_mode    (y_mode)
    );

    always #5 clk = ~clk;

    // Reference: full product minus the discarded low-column contributions.
    function automatic logic [15:0] model(input logic [7:0] av, input logic [7:0] bv,
                                          input logic mv);
        int unsigned p;
        int unsigned disc;
        p = 32'(av) * 32'(bv);
        if (mv) begin
            disc = 0;
            for (int i = 0; i < T; i++)
                for (int j = 0; j < T - i; j++)
                    if (av[j] && bv[i]) disc += (32'd1 << (i + j));
            p = p - disc;
`ifdef APPROX_MULT_COMP_EN
            p = p + (32'd1 << T);
`endif
        end
        return 16'(p);
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp)
        else begin
            fails++;
            $error("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One clock cycle: drive at negedge, score the handshakes, advance.
    task automatic do_cycle(input logic v, input logic [7:0] av, input logic [7:0] bv,
                            input logic mv, input logic ordy, input logic [15:0] ey,
                            output bit acc);
        in_valid  = v;
        a         = av;
        b         = bv;
        mode      = mv;
        out_ready = ordy;
        #1;
        chk("in_ready", 32'(in_ready), 32'(ordy || (q_y.size() < 2)));
        if (out_valid) begin
            if (q_y.size() == 0) begin
                chk("spurious_out", 32'(out_valid), 32'd0);
            end else begin
                chk(ordy ? "y" : "stall_y", 32'(y), 32'(q_y[0]));
                chk(ordy ? "y_mode" : "stall_y_mode", 32'(y_mode), 32'(q_m[0]));
                if (ordy) begin
                    if (lat_chk) chk("latency", 32'(cyc - q_c[0]), 32'd2);
                    void'(q_y.pop_front());
                    void'(q_m.pop_front());
                    void'(q_c.pop_front());
                end
            end
        end
        acc = v && in_ready;
        if (acc) begin
            q_y.push_back(ey);
            q_m.push_back(mv);
            q_c.push_back(cyc);
        end
        @(negedge clk);
        cyc++;
    endtask

    task automatic send(input logic [7:0] av, input logic [7:0] bv, input logic mv,
                        input logic [15:0] ey);
        bit acc;
        acc = 1'b0;
        for (int k = 0; k < 10 && !acc; k++) do_cycle(1'b1, av, bv, mv, 1'b1, ey, acc);
        if (!acc) chk("send_timeout", 32'(acc), 32'd1);
    endtask

    task automatic idle(input int n, input logic ordy);
        bit acc;
        for (int k = 0; k < n; k++) do_cycle(1'b0, 8'd0, 8'd0, 1'b0, ordy, 16'd0, acc);
    endtask

    initial begin
        bit acc;
        int n;
        logic [7:0] av, bv;
        logic mv, vv, rv;

        rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; mode = 1'b0; out_ready = 1'b0;
        #3;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_y", 32'(y), 32'd0);
        chk("rst_y_mode", 32'(y_mode), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed vectors with latency checking.
        lat_chk = 1'b1;
        idle(1, 1'b1);
        send(8'd255, 8'd255, 1'b0, 16'd65025);
        idle(3, 1'b1);
        send(8'd255, 8'd255, 1'b1, Y_FF_APX);
        send(8'd240, 8'd240, 1'b1, Y_F0_APX);
        send(8'd15, 8'd15, 1'b1, Y_0F_APX);
        idle(3, 1'b1);

        // Back-to-back mixed-mode stream.
        send(8'd1, 8'd1, 1'b0, 16'd1);
        send(8'd15, 8'd15, 1'b1, Y_0F_APX);
        send(8'd2, 8'd3, 1'b0, 16'd6);
        idle(4, 1'b1);
        chk("b2b_drained", 32'(q_y.size()), 32'd0);

        // Four-beat stream with out_ready low for five cycles.
        lat_chk = 1'b0;
        n = 0;
        for (int k = 0; k < 14; k++) begin
            av = 8'(3 + 17 * n);
            bv = 8'(200 - 9 * n);
            mv = n[0];
            do_cycle(n < 4, av, bv, mv, (k == 0) || (k >= 6), model(av, bv, mv), acc);
            if (acc) n++;
            if (k == 4) chk("stall_out_valid", 32'(out_valid), 32'd1);
        end
        chk("stall_beats_sent", 32'(n), 32'd4);
        chk("stall_drained", 32'(q_y.size()), 32'd0);

        // Randomized traffic and back-pressure.
        for (int k = 0; k < 400; k++) begin
            av = 8'($urandom_range(0, 255));
            bv = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 7) == 0) av = 8'hFF;
            if ($urandom_range(0, 7) == 0) bv = 8'h00;
            mv = 1'($urandom_range(0, 1));
            vv = ($urandom_range(0, 3) != 0);
            rv = ($urandom_range(0, 9) < 7);
            do_cycle(vv, av, bv, mv, rv, model(av, bv, mv), acc);
        end
        for (int k = 0; k < 10 && q_y.size() != 0; k++) idle(1, 1'b1);
        chk("rand_drained", 32'(q_y.size()), 32'd0);

        // Reset with two beats in flight.
        do_cycle(1'b1, 8'd9, 8'd7, 1'b1, 1'b0, model(8'd9, 8'd7, 1'b1), acc);
        do_cycle(1'b1, 8'd5, 8'd6, 1'b1, 1'b0, model(8'd5, 8'd6, 1'b1), acc);
        chk("inflight_before_rst", 32'(q_y.size()), 32'd2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_out_valid", 32'(out_valid), 32'd0);
        chk("async_rst_y", 32'(y), 32'd0);
        chk("async_rst_y_mode", 32'(y_mode), 32'd0);
        chk("async_rst_in_ready", 32'(in_ready), 32'd1);
        q_y.delete();
        q_m.delete();
        q_c.delete();
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            idle(1, 1'b1);
            chk("post_rst_no_out", 32'(out_valid), 32'd0);
        end

        // Pipeline still healthy after reset.
        lat_chk = 1'b1;
        send(8'd12, 8'd11, 1'b0, 16'd132);
        idle(3, 1'b1);
        chk("final_drained", 32'(q_y.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Absolute time bound so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
